// File: rtl/move_sequencer.sv
// Sokoban move sequencer: validates direction requests against the wall/box
// bitmaps, strobes position updates to the game core, and keeps an undo history.
//
// state  | meaning
// IDLE   | waiting for retry / retract / direction request
// CHECK  | legality check of the latched direction against man/wall/box
// COMMIT | update strobe for a legal move, history push on exit
// UNDO   | update strobe reversing the newest history entry, pop on exit
module move_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dir_valid,
  input  logic [1:0]    dir,
  output logic          dir_ready,
  input  logic          retract,
  input  logic          retry,
  input  logic [5:0]    man,
  input  logic [63:0]   wall,
  input  logic [63:0]   box,
  output logic          upd_valid,
  output logic [5:0]    upd_man,
  output logic          upd_box_mv,
  output logic [5:0]    upd_box_from,
  output logic [5:0]    upd_box_to,
  output logic          blocked,
  output logic          retry_req,
  output logic [AW:0]   hist_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] UNDO   = 2'd3;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    dir_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [2:0]    hist_mem [DEPTH];

  logic          t1_ok;
  logic          t2_ok;
  logic [5:0]    t1;
  logic [5:0]    t2;
  logic          t1_has_box;
  logic          legal;

  logic [2:0]    entry;
  logic [5:0]    undo_man;
  logic [5:0]    undo_box_from;

  // Off-board detection uses the row (bits 5:3) and column (bits 2:0) fields.
  function automatic logic step_ok(input logic [5:0] c, input logic [1:0] d);
    logic ok;
    case (d)
      2'b00:   ok = (c[5:3] != 3'd0);
      2'b01:   ok = (c[5:3] != 3'd7);
      2'b10:   ok = (c[2:0] != 3'd0);
      default: ok = (c[2:0] != 3'd7);
    endcase
    return ok;
  endfunction

  function automatic logic [5:0] step_to(input logic [5:0] c, input logic [1:0] d);
    logic [5:0] n;
    case (d)
      2'b00:   n = c - 6'd8;
      2'b01:   n = c + 6'd8;
      2'b10:   n = c - 6'd1;
      default: n = c + 6'd1;
    endcase
    return n;
  endfunction

  always_comb begin
    t1         = step_to(man, dir_q);
    t2         = step_to(t1, dir_q);
    t1_ok      = step_ok(man, dir_q);
    t2_ok      = t1_ok && step_ok(t1, dir_q);
    t1_has_box = box[t1];
    legal      = t1_ok && !wall[t1] &&
                 (!t1_has_box || (t2_ok && !wall[t2] && !box[t2]));
  end

  // Undo reads the newest entry {dir, pushed}; opposite direction flips bit 0.
  always_comb begin
    rd_ptr        = wr_ptr - AW'(1);
    entry         = hist_mem[rd_ptr];
    undo_man      = step_to(man, entry[2:1] ^ 2'b01);
    undo_box_from = step_to(man, entry[2:1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dir_q        <= 2'b00;
      wr_ptr       <= '0;
      cnt          <= '0;
      upd_valid    <= 1'b0;
      upd_man      <= 6'd0;
      upd_box_mv   <= 1'b0;
      upd_box_from <= 6'd0;
      upd_box_to   <= 6'd0;
      blocked      <= 1'b0;
      retry_req    <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      blocked   <= 1'b0;
      retry_req <= 1'b0;
      case (state)
        IDLE: begin
          if (retry) begin
            retry_req <= 1'b1;
            wr_ptr    <= '0;
            cnt       <= '0;
          end else if (retract && (cnt != '0)) begin
            state        <= UNDO;
            upd_valid    <= 1'b1;
            upd_man      <= undo_man;
            upd_box_mv   <= entry[0];
            upd_box_from <= undo_box_from;
            upd_box_to   <= man;
          end else if (dir_valid) begin
            state <= CHECK;
            dir_q <= dir;
          end
        end
        CHECK: begin
          if (legal) begin
            state        <= COMMIT;
            upd_valid    <= 1'b1;
            upd_man      <= t1;
            upd_box_mv   <= t1_has_box;
            upd_box_from <= t1;
            upd_box_to   <= t2;
          end else begin
            state   <= IDLE;
            blocked <= 1'b1;
          end
        end
        COMMIT: begin
          state  <= IDLE;
          wr_ptr <= wr_ptr + AW'(1);
          if (cnt != FULL) cnt <= cnt + (AW+1)'(1);
        end
        default: begin
          state  <= IDLE;
          wr_ptr <= rd_ptr;
          cnt    <= cnt - (AW+1)'(1);
        end
      endcase
    end
  end

  // When full, the push lands on the oldest entry since wr_ptr has wrapped onto it.
  always_ff @(posedge clk) begin
    if (state == COMMIT) hist_mem[wr_ptr] <= {dir_q, upd_box_mv};
  end

  assign dir_ready  = (state == IDLE);
  assign hist_count = cnt;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed plus randomized bench for move_sequencer; a board-level model
// (man position, wall/box bitmaps, move history queue) predicts every strobe.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dir_valid;
  logic [1:0]  dir;
  logic        dir_ready;
  logic        retract;
  logic        retry;
  logic [5:0]  man;
  logic [63:0] wall;
  logic [63:0] box;
  logic        upd_valid;
  logic [5:0]  upd_man;
  logic        upd_box_mv;
  logic [5:0]  upd_box_from;
  logic [5:0]  upd_box_to;
  logic        blocked;
  logic        retry_req;
  logic [4:0]  hist_count;

  move_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .dir_valid(dir_valid), .dir(dir),
    .dir_ready(dir_ready), .retract(retract), .retry(retry), .man(man),
    .wall(wall), .box(box), .upd_valid(upd_valid), .upd_man(upd_man),
    .upd_box_mv(upd_box_mv), .upd_box_from(upd_box_from),
    .upd_box_to(upd_box_to), .blocked(blocked), .retry_req(retry_req),
    .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit p; } hist_t;

  int          n_pass = 0;
  int          n_checks = 0;
  int          m_man;
  logic [63:0] m_wall;
  logic [63:0] m_box;
  hist_t       hq[$];

  assign man  = m_man[5:0];
  assign wall = m_wall;
  assign box  = m_box;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Board step using row/column arithmetic; returns 0 when leaving the board.
  function automatic bit mstep(input int c, input int d, output int n);
    int r, cl;
    r  = c / 8;
    cl = c % 8;
    case (d)
      0: r  = r - 1;
      1: r  = r + 1;
      2: cl = cl - 1;
      default: cl = cl + 1;
    endcase
    n = r * 8 + cl;
    return (r >= 0 && r < 8 && cl >= 0 && cl < 8);
  endfunction

  task automatic do_move(input int d);
    int t1, t2;
    bit v1, v2, legal, pushb;
    t1 = 0; t2 = 0;
    v1 = mstep(m_man, d, t1);
    v2 = v1 ? mstep(t1, d, t2) : 1'b0;
    legal = 1'b0;
    pushb = 1'b0;
    if (v1 && !m_wall[t1]) begin
      pushb = m_box[t1];
      legal = !pushb || (v2 && !m_wall[t2] && !m_box[t2]);
    end
    check("move_ready_before", dir_ready, 1);
    dir_valid = 1'b1;
    dir = 2'(d);
    @(posedge clk);
    @(negedge clk);
    dir_valid = 1'b0;
    check("move_check_cycle_valid", upd_valid, 0);
    check("move_check_cycle_ready", dir_ready, 0);
    @(negedge clk);
    if (legal) begin
      check("move_upd_valid", upd_valid, 1);
      check("move_blocked", blocked, 0);
      check("move_upd_man", upd_man, t1);
      check("move_box_mv", upd_box_mv, pushb);
      if (pushb) begin
        check("move_box_from", upd_box_from, t1);
        check("move_box_to", upd_box_to, t2);
        m_box[t1] = 1'b0;
        m_box[t2] = 1'b1;
      end
      m_man = t1;
      hq.push_back('{d: d, p: pushb});
      if (hq.size() > 16) void'(hq.pop_front());
      @(negedge clk);
      check("move_ready_after", dir_ready, 1);
      check("move_strobe_width", upd_valid, 0);
    end else begin
      check("move_blocked", blocked, 1);
      check("move_no_upd", upd_valid, 0);
      check("move_ready_blocked", dir_ready, 1);
      @(negedge clk);
      check("move_blocked_width", blocked, 0);
    end
    check("move_hist_count", hist_count, hq.size());
  endtask

  task automatic do_retract();
    hist_t e;
    int back, fwd;
    int opp[4] = '{1, 0, 3, 2};
    back = 0; fwd = 0;
    if (hq.size() == 0) begin
      retract = 1'b1;
      @(posedge clk);
      @(negedge clk);
      retract = 1'b0;
      check("retract_empty_valid", upd_valid, 0);
      check("retract_empty_blocked", blocked, 0);
      check("retract_empty_ready", dir_ready, 1);
      check("retract_empty_hist", hist_count, 0);
    end else begin
      e = hq.pop_back();
      void'(mstep(m_man, opp[e.d], back));
      void'(mstep(m_man, e.d, fwd));
      retract = 1'b1;
      @(posedge clk);
      @(negedge clk);
      retract = 1'b0;
      check("undo_valid", upd_valid, 1);
      check("undo_ready", dir_ready, 0);
      check("undo_man", upd_man, back);
      check("undo_box_mv", upd_box_mv, e.p);
      if (e.p) begin
        check("undo_box_from", upd_box_from, fwd);
        check("undo_box_to", upd_box_to, m_man);
        m_box[fwd]   = 1'b0;
        m_box[m_man] = 1'b1;
      end
      m_man = back;
      @(negedge clk);
      check("undo_ready_after", dir_ready, 1);
      check("undo_strobe_width", upd_valid, 0);
      check("undo_hist_count", hist_count, hq.size());
    end
  endtask

  task automatic do_retry(input bit with_retract);
    retry = 1'b1;
    retract = with_retract;
    @(posedge clk);
    @(negedge clk);
    retry = 1'b0;
    retract = 1'b0;
    hq.delete();
    check("retry_req", retry_req, 1);
    check("retry_no_upd", upd_valid, 0);
    check("retry_ready", dir_ready, 1);
    check("retry_hist", hist_count, 0);
    @(negedge clk);
    check("retry_req_width", retry_req, 0);
  endtask

  task automatic random_board();
    int start, c;
    m_wall = '0;
    m_box  = '0;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 7))
        0: m_wall[i] = 1'b1;
        1: m_box[i]  = 1'b1;
        default: ;
      endcase
    end
    start = int'($urandom_range(0, 63));
    m_man = start;
    for (int k = 0; k < 64; k++) begin
      c = (start + k) % 64;
      if (!m_wall[c] && !m_box[c]) begin
        m_man = c;
        break;
      end
    end
    m_wall[m_man] = 1'b0;
    m_box[m_man]  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    dir_valid = 1'b0;
    dir = 2'b00;
    retract = 1'b0;
    retry = 1'b0;
    m_man = 9;
    m_wall = '0;
    m_box = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", dir_ready, 1);
    check("rst_valid", upd_valid, 0);
    check("rst_blocked", blocked, 0);
    check("rst_retry_req", retry_req, 0);
    check("rst_hist", hist_count, 0);
    check("rst_upd_man", upd_man, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // free move, push, undo of the push
    do_move(3);
    do_retry(0);
    m_man = 9; m_box = '0; m_box[10] = 1'b1;
    do_move(3);
    do_retract();
    do_retract();

    // blocked box chain, board edges, wall
    m_man = 9; m_box = '0; m_box[10] = 1'b1; m_box[11] = 1'b1;
    do_move(3);
    m_box = '0; m_man = 0;
    do_move(0);
    do_move(2);
    m_man = 9; m_wall[1] = 1'b1;
    do_move(0);
    m_wall = '0;

    // overflow: 20 moves, 16 undos, 17th ignored
    m_man = 9;
    for (int i = 0; i < 20; i++) do_move((i % 2 == 0) ? 3 : 2);
    for (int i = 0; i < 17; i++) do_retract();

    // priority: retry wins over simultaneous retract
    do_move(1);
    do_move(3);
    do_retry(1);

    // reset during CHECK
    m_man = 9;
    do_move(3);
    do_move(3);
    dir_valid = 1'b1;
    dir = 2'b01;
    @(posedge clk);
    @(negedge clk);
    dir_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", upd_valid, 0);
    check("midrst_blocked", blocked, 0);
    check("midrst_ready", dir_ready, 1);
    check("midrst_hist", hist_count, 0);
    check("midrst_upd_man", upd_man, 0);
    check("midrst_box_mv", upd_box_mv, 0);
    @(negedge clk);
    check("midrst_no_strobe", upd_valid, 0);
    reset_n = 1'b1;
    hq.delete();
    @(negedge clk);
    do_move(1);

    // randomized play on several boards
    for (int b = 0; b < 4; b++) begin
      do_retry(0);
      random_board();
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 3) == 0) do_retract();
        else do_move(int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Move sequencer for the 8x8 Sokoban board. It accepts direction requests from the keyboard front end and checks each move against the current wall/box bitmaps. Legal moves become single-cycle update strobes to the game core, and every committed move is recorded in a circular undo history. It also serves retract (undo one move) and retry (clear history, request a level restart). It sits between the PS/2 interface and the game core, and is the only writer of man/box position changes.

## Interface
- DEPTH, 16, undo history entries (power of two)
- AW, 4, log2(DEPTH)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- dir_valid  in  1  direction request valid
- dir  in  2  00 up, 01 down, 10 left, 11 right
- dir_ready  out  1  request accepted when dir_valid && dir_ready
- retract  in  1  one-cycle undo pulse
- retry  in  1  one-cycle restart pulse
- man  in  6  current man cell (row*8+col)
- wall  in  64  wall bitmap, bit i = cell i
- box  in  64  box bitmap
- upd_valid  out  1  one-cycle update strobe to the game core
- upd_man  out  6  new man cell
- upd_box_mv  out  1  a box moves with this update
- upd_box_from  out  6  box source cell
- upd_box_to  out  6  box destination cell
- blocked  out  1  one-cycle pulse: request rejected
- retry_req  out  1  one-cycle pulse: game core reloads the level
- hist_count  out  AW+1  valid history entries, 0..DEPTH

## Operation
- States: IDLE, CHECK, COMMIT, UNDO.
  - dir_ready = (state == IDLE).
- Command priority, sampled only in IDLE: retry > retract > dir_valid. Pulses arriving outside IDLE are dropped.
- Cell stepping: up −8, down +8, left −1, right +1.
  - Off-board steps are invalid: row 0 up, row 7 down, col 0 left, col 7 right.
  - t1 = man stepped once. t2 = t1 stepped again in the same direction.
- CHECK: the move is legal iff all of the following hold:
  - t1 is valid and wall[t1]=0;
  - and either box[t1]=0, or (t2 is valid, wall[t2]=0 and box[t2]=0).
- A legal move goes to COMMIT. An illegal move pulses blocked and returns to IDLE; history is unchanged.
- COMMIT:
  - upd_valid=1, upd_man=t1.
  - upd_box_mv = box[t1], upd_box_from=t1, upd_box_to=t2.
  - Push {dir, upd_box_mv} at wr_ptr, then wr_ptr+1 (mod DEPTH).
  - hist_count saturates at DEPTH; when full, the oldest entry is overwritten.
- retract in IDLE with hist_count=0: ignored, no pulse, no state change.
- retract in IDLE with hist_count>0: go to UNDO, read entry at wr_ptr−1. In UNDO, with p = man:
  - upd_man = p stepped opposite to the stored dir.
  - If the stored push bit is set: upd_box_from = p stepped in the stored dir, upd_box_to = p, upd_box_mv=1.
  - upd_valid=1, wr_ptr−1, hist_count−1, return to IDLE.
  - No legality check in UNDO: the reverse of a committed move is always legal.
- retry in IDLE: retry_req=1 for one cycle, wr_ptr=0, hist_count=0, state stays IDLE.
- upd_box_from/to/man are don't-care when upd_valid=0; the bench checks them only on strobe.
- man/wall/box must be stable from acceptance through the update cycle. The game core applies an update one cycle after upd_valid.

## Timing
- Reset (async assert, sync release): state IDLE, wr_ptr 0, hist_count 0. All strobes and update fields 0, dir_ready 1.
- Reset mid-operation aborts any CHECK/COMMIT/UNDO with no strobe; history is lost.
- Move acceptance at edge N:
  - CHECK during cycle N+1.
  - upd_valid (legal) or blocked (illegal) in cycle N+2.
  - dir_ready high again in cycle N+3 for a legal move, N+2 for an illegal one.
- Retract acceptance at edge N: upd_valid in cycle N+1, dir_ready in N+2.
- Retry: retry_req in the cycle after acceptance. dir_ready stays 1.
- Throughput: one move per 3 cycles; back-to-back dir_valid is serviced in order.
- blocked, retry_req and upd_valid are mutually exclusive and never wider than one cycle.

## Test plan
- Free move: man=9, dir=11, wall/box 0 → upd_valid 2 cycles after accept, upd_man=10, upd_box_mv=0, hist_count=1.
- Push: man=9, box bit 10, dir=11 → upd_man=10, upd_box_from=10, upd_box_to=11, upd_box_mv=1. Repeat with box bit 11 also set → blocked=1, no upd_valid.
- Edges and walls: man=0 with dir=00 and with dir=10 → blocked each time. man=9 with wall bit 1 set and dir=00 → blocked. hist_count unchanged in all cases.
- Undo: after the push case (man=10, box at 11), retract → upd_man=9, upd_box_from=11, upd_box_to=10, hist_count 0. A second retract → no pulse.
- Overflow: 20 legal free moves → hist_count=16. 16 retracts undo the last 16 moves in reverse order; the 17th retract is ignored.
- Priority/reset: retry and retract in the same IDLE cycle → only retry_req, hist_count=0. reset_n low during CHECK → no upd_valid, all outputs at reset values.
